// File: rtl/softmax_row_scheduler_pkg.sv
// Shared widths, S5.10 constants and FSM state encodings for the softmax row scheduler.
package softmax_row_scheduler_pkg;

    localparam int ROWS = 64;
    localparam int DW   = 16;
    localparam int AW   = 6;

    localparam logic [DW-1:0] NEG8     = 16'hE000;
    localparam logic [DW-1:0] ONE      = 16'h0400;
    localparam logic [DW-1:0] MASK_VAL = NEG8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD    = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_WR    = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

endpackage

// File: rtl/softmax_row_scheduler_causal_row_mask.sv
// Combinational causal mask: column c of row r becomes MASK_VAL when enabled and c > r.
module softmax_row_scheduler_causal_row_mask
    import softmax_row_scheduler_pkg::*;
(
    input  logic [AW-1:0]      row,
    input  logic               enable,
    input  logic [ROWS*DW-1:0] row_in,
    output logic [ROWS*DW-1:0] row_out
);

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_col
            localparam logic [AW:0] COL = (AW+1)'(gi);
            assign row_out[gi*DW +: DW] = (enable && (COL > {1'b0, row})) ? MASK_VAL
                                                                          : row_in[gi*DW +: DW];
        end
    endgenerate

endmodule

// File: rtl/softmax_row_scheduler.sv
// Walks every row of a score matrix through the softmax engine and writes the results back.
module softmax_row_scheduler
    import softmax_row_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AW-1:0]      cfg_rows,
    input  logic               cfg_causal,
    output logic               sc_rd_en,
    output logic [AW-1:0]      sc_rd_addr,
    input  logic [ROWS*DW-1:0] sc_rd_data,
    output logic               sm_start,
    output logic [ROWS*DW-1:0] sm_qk,
    input  logic               sm_valid,
    input  logic [ROWS*DW-1:0] sm_out,
    output logic               res_wr_en,
    output logic [AW-1:0]      res_wr_addr,
    output logic [ROWS*DW-1:0] res_wr_data,
    input  logic               res_wr_ready,
    output logic               busy,
    output logic               done
);

    logic [2:0]         state_reg, state_next;
    logic [AW-1:0]      row_reg;
    logic [AW-1:0]      last_row_reg;
    logic               causal_reg;
    logic [ROWS*DW-1:0] qk_reg;
    logic [ROWS*DW-1:0] res_reg;
    logic [ROWS*DW-1:0] masked_row;

    softmax_row_scheduler_causal_row_mask u_mask (
        .row     (row_reg),
        .enable  (causal_reg),
        .row_in  (sc_rd_data),
        .row_out (masked_row)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_RD;
            ST_RD:    state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_RUN;
            ST_RUN:   if (sm_valid) state_next = ST_WR;
            ST_WR:    if (res_wr_ready) state_next = ST_DRAIN;
            // Wait out the engine's trailing valid so the next start never sees a stale result.
            ST_DRAIN: if (!sm_valid) state_next = (row_reg == last_row_reg) ? ST_DONE : ST_RD;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            row_reg      <= '0;
            last_row_reg <= '0;
            causal_reg   <= 1'b0;
            qk_reg       <= '0;
            res_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                row_reg      <= '0;
                last_row_reg <= cfg_rows;
                causal_reg   <= cfg_causal;
            end
            if (state_reg == ST_LOAD) begin
                qk_reg <= masked_row;
            end
            if (state_reg == ST_RUN && sm_valid) begin
                res_reg <= sm_out;
            end
            if (state_reg == ST_DRAIN && !sm_valid && row_reg != last_row_reg) begin
                row_reg <= row_reg + AW'(1);
            end
        end
    end

    assign sc_rd_en    = (state_reg == ST_RD);
    assign sc_rd_addr  = row_reg;
    assign sm_start    = (state_reg == ST_RUN);
    assign sm_qk       = qk_reg;
    assign res_wr_en   = (state_reg == ST_WR);
    assign res_wr_addr = row_reg;
    assign res_wr_data = res_reg;
    assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done        = (state_reg == ST_DONE);

endmodule
